// File: rtl/fb_line_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : fb_line_scheduler
// Purpose  : Arbitrates the single-port framebuffer between scanline fetches
//            into the display line buffer and draw-engine writes. A draw slot
//            is stolen from the fetch after every BURST consecutive reads.
//            The read for a word issued in cycle c is captured at the end of
//            cycle c+RD_LAT-1, so its line-buffer write shows in cycle c+RD_LAT.
// Revision : 1.0 - initial release
// ============================================================================
module fb_line_scheduler #(
  parameter int LINE_WORDS = 320,
  parameter int LINES      = 240,
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 16,
  parameter int RD_LAT     = 2,
  parameter int BURST      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              line_req,
  input  logic [8:0]        line_num,
  output logic              fetch_busy,
  output logic              fetch_overrun,
  output logic              lb_we,
  output logic [8:0]        lb_addr,
  output logic [DATA_W-1:0] lb_wdata,
  input  logic              dr_req,
  input  logic [ADDR_W-1:0] dr_addr,
  input  logic [DATA_W-1:0] dr_data,
  output logic              dr_gnt,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(LINE_WORDS + 1);
  localparam int BST_W = $clog2(BURST + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_base;
  logic [CNT_W-1:0]    r_issue_cnt;
  logic [BST_W-1:0]    r_burst_cnt;
  logic [RD_LAT-1:0]   r_pv;
  logic [8:0]          r_pcol [RD_LAT];
  logic [DATA_W-1:0]   r_lb_wdata;
  logic                r_overrun;

  logic                w_line_ok;
  logic [ADDR_W-1:0]   w_base_new;
  logic                w_slot;
  logic                w_steal;
  logic                w_issue;
  logic                w_last;
  logic                w_abort;
  logic                w_start;
  logic                w_inflight;
  logic                w_cap;

  assign w_line_ok  = 32'(line_num) < LINES;
  assign w_base_new = ADDR_W'(line_num) * ADDR_W'(LINE_WORDS);
  assign w_slot     = (r_burst_cnt == BST_W'(BURST));
  assign w_steal    = (r_state == S_FETCH) && w_slot && dr_req;
  assign w_issue    = (r_state == S_FETCH) && !w_steal;
  assign w_last     = w_issue && (r_issue_cnt == CNT_W'(LINE_WORDS - 1));
  assign w_abort    = line_req && (r_state != S_IDLE);
  assign w_start    = line_req && w_line_ok;

  // Reads still short of the final pipeline stage keep DRAIN alive; the last
  // stage is being written to the line buffer this very cycle.
  generate
    if (RD_LAT > 1) begin : g_pipe_deep
      assign w_inflight = |r_pv[RD_LAT-2:0];
      assign w_cap      = r_pv[RD_LAT-2];
    end else begin : g_pipe_single
      assign w_inflight = 1'b0;
      assign w_cap      = w_issue;
    end
  endgenerate

  // Next-state selection; any line request while busy aborts the fetch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_FETCH;
      S_FETCH: if (w_last) w_state_nxt = S_DRAIN;
      S_DRAIN: if (!w_inflight) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_abort) w_state_nxt = w_line_ok ? S_FETCH : S_IDLE;
  end

  // Memory port steering: fetch read, draw write, or idle. Reset masks grants.
  always_comb begin
    dr_gnt    = 1'b0;
    mem_re    = w_issue;
    mem_addr  = '0;
    mem_wdata = dr_data;
    if (rst_n && dr_req && ((r_state == S_IDLE) || (r_state == S_DRAIN) || w_steal))
      dr_gnt = 1'b1;
    if (w_issue)
      mem_addr = r_base + ADDR_W'(r_issue_cnt);
    else if (dr_gnt)
      mem_addr = dr_addr;
    mem_we = dr_gnt;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Fetch base, issue counter and burst counter for slot stealing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base      <= '0;
      r_issue_cnt <= '0;
      r_burst_cnt <= '0;
    end else if (w_start) begin
      r_base      <= w_base_new;
      r_issue_cnt <= '0;
      r_burst_cnt <= '0;
    end else if (w_steal) begin
      r_burst_cnt <= '0;
    end else if (w_issue) begin
      r_issue_cnt <= r_issue_cnt + 1'b1;
      r_burst_cnt <= w_slot ? BST_W'(1) : r_burst_cnt + 1'b1;
    end
  end

  // Valid/column shift pipeline tracking in-flight reads; flushed on abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pv <= '0;
      for (int i = 0; i < RD_LAT; i++) r_pcol[i] <= '0;
    end else if (w_abort) begin
      r_pv <= '0;
    end else begin
      r_pv[0]   <= w_issue;
      r_pcol[0] <= 9'(r_issue_cnt);
      for (int i = 1; i < RD_LAT; i++) begin
        r_pv[i]   <= r_pv[i-1];
        r_pcol[i] <= r_pcol[i-1];
      end
    end
  end

  // Capture returning read data alongside its column in the final stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_lb_wdata <= '0;
    else if (w_cap && !w_abort)  r_lb_wdata <= mem_rdata;
  end

  // Sticky overrun flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_overrun <= 1'b0;
    else if (w_abort) r_overrun <= 1'b1;
  end

  assign fetch_busy    = (r_state != S_IDLE);
  assign fetch_overrun = r_overrun;
  assign lb_we         = r_pv[RD_LAT-1];
  assign lb_addr       = r_pcol[RD_LAT-1];
  assign lb_wdata      = r_lb_wdata;

endmodule
`default_nettype wire

// File: tb/tb_fb_line_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_fb_line_scheduler
// Purpose  : Directed vectors and fetch sequences for fb_line_scheduler with
//            a framebuffer model that returns the read address as data.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fb_line_scheduler;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              line_req = 1'b0;
  logic [8:0]        line_num = '0;
  logic              fetch_busy, fetch_overrun, lb_we;
  logic [8:0]        lb_addr;
  logic [DATA_W-1:0] lb_wdata;
  logic              dr_req = 1'b0;
  logic [ADDR_W-1:0] dr_addr = '0;
  logic [DATA_W-1:0] dr_data = '0;
  logic              dr_gnt, mem_re, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [DATA_W-1:0] r_mem_q;

  always #5 clk = ~clk;

  fb_line_scheduler dut (
    .clk(clk), .rst_n(rst_n), .line_req(line_req), .line_num(line_num),
    .fetch_busy(fetch_busy), .fetch_overrun(fetch_overrun), .lb_we(lb_we),
    .lb_addr(lb_addr), .lb_wdata(lb_wdata), .dr_req(dr_req), .dr_addr(dr_addr),
    .dr_data(dr_data), .dr_gnt(dr_gnt), .mem_re(mem_re), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Framebuffer model: one registered read stage, data = address.
  always @(posedge clk) r_mem_q <= mem_re ? mem_addr[DATA_W-1:0] : 16'hDEAD;
  assign mem_rdata = r_mem_q;

  int checks = 0, failures = 0, cyc = 0;
  int lbw, lb_bad, reads, gnt_fetch, both_hi, gnt_bad, first_lb, last_busy, exp_base;

  typedef struct {
    logic              lreq;
    logic [8:0]        lnum;
    logic              dreq;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] ddata;
    logic              e_gnt;
    logic              e_re;
    logic              e_busy;
  } vec_t;
  vec_t vt [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clr(input int base);
    lbw = 0; lb_bad = 0; reads = 0; gnt_fetch = 0; both_hi = 0; gnt_bad = 0;
    first_lb = -1; last_busy = -1; exp_base = base;
  endtask

  // Sample the current cycle mid-period and accumulate scoreboard counters.
  task automatic half();
    @(negedge clk);
    if (mem_re && mem_we) both_hi++;
    if (dr_gnt) begin
      if (!dr_req || !mem_we || mem_addr !== dr_addr || mem_wdata !== dr_data) gnt_bad++;
      if (fetch_busy && reads < 320) gnt_fetch++;
    end
    if (mem_re) reads++;
    if (lb_we === 1'b1) begin
      if (first_lb < 0) first_lb = cyc;
      if (lb_addr !== 9'(lbw) || lb_wdata !== 16'(exp_base + lbw)) lb_bad++;
      lbw++;
    end
    if (fetch_busy) last_busy = cyc;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to_idle(input int maxc);
    bit done = 0;
    for (int i = 0; i < maxc && !done; i++) begin
      half();
      if (!fetch_busy) done = 1;
      adv();
    end
    check("idle_timeout", {31'd0, done}, 32'd1);
  endtask

  int t;
  bit found;

  initial begin
    // Reset with requests pending: everything must stay quiet.
    line_req = 1; line_num = 9'd3; dr_req = 1; dr_addr = 17'h155; dr_data = 16'hAAAA;
    repeat (3) adv();
    half();
    check("rst_dr_gnt", {31'd0, dr_gnt}, 0);
    check("rst_mem_re", {31'd0, mem_re}, 0);
    check("rst_mem_we", {31'd0, mem_we}, 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_busy", {31'd0, fetch_busy}, 0);
    check("rst_overrun", {31'd0, fetch_overrun}, 0);
    check("rst_lb_we", {31'd0, lb_we}, 0);
    check("rst_lb_addr", 32'(lb_addr), 0);
    check("rst_lb_wdata", 32'(lb_wdata), 0);
    adv();
    line_req = 0; dr_req = 0;
    adv();
    rst_n = 1;
    adv();

    // Idle-state vectors: draw grants, ignored out-of-range line requests.
    vt[0] = '{1'b0, 9'd0,   1'b1, 17'h1ABCD, 16'h1234, 1'b1, 1'b0, 1'b0};
    vt[1] = '{1'b0, 9'd0,   1'b0, 17'h00055, 16'h5555, 1'b0, 1'b0, 1'b0};
    vt[2] = '{1'b1, 9'd240, 1'b0, 17'h00000, 16'h0000, 1'b0, 1'b0, 1'b0};
    vt[3] = '{1'b0, 9'd0,   1'b0, 17'h00000, 16'h0000, 1'b0, 1'b0, 1'b0};
    vt[4] = '{1'b1, 9'd300, 1'b1, 17'h00010, 16'hBEEF, 1'b1, 1'b0, 1'b0};
    vt[5] = '{1'b0, 9'd0,   1'b0, 17'h00000, 16'h0000, 1'b0, 1'b0, 1'b0};
    vt[6] = '{1'b1, 9'd511, 1'b0, 17'h00000, 16'h0000, 1'b0, 1'b0, 1'b0};
    vt[7] = '{1'b0, 9'd0,   1'b1, 17'h1FFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    clr(0);
    for (int i = 0; i < 8; i++) begin
      line_req = vt[i].lreq; line_num = vt[i].lnum; dr_req = vt[i].dreq;
      dr_addr = vt[i].daddr; dr_data = vt[i].ddata;
      half();
      check($sformatf("v%0d_gnt", i), {31'd0, dr_gnt}, {31'd0, vt[i].e_gnt});
      check($sformatf("v%0d_we", i), {31'd0, mem_we}, {31'd0, vt[i].e_gnt});
      check($sformatf("v%0d_re", i), {31'd0, mem_re}, {31'd0, vt[i].e_re});
      check($sformatf("v%0d_busy", i), {31'd0, fetch_busy}, {31'd0, vt[i].e_busy});
      if (vt[i].e_gnt) begin
        check($sformatf("v%0d_waddr", i), 32'(mem_addr), 32'(vt[i].daddr));
        check($sformatf("v%0d_wdata", i), 32'(mem_wdata), 32'(vt[i].ddata));
      end
      adv();
    end
    line_req = 0; dr_req = 0;
    repeat (3) begin half(); adv(); end
    check("idle_reads", reads, 0);
    check("idle_lb_writes", lbw, 0);
    check("idle_overrun", {31'd0, fetch_overrun}, 0);

    // Uncontended fetch of line 3, plus a draw pulse during DRAIN.
    clr(960);
    line_req = 1; line_num = 9'd3;
    half(); t = cyc; adv();
    line_req = 0;
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      half();
      if (reads == 320) found = 1;
      else adv();
    end
    check("last_read_found", {31'd0, found}, 1);
    check("last_read_cycle", cyc - t, 320);
    adv();
    dr_req = 1; dr_addr = 17'h0ABCD; dr_data = 16'hC0DE;
    half();
    check("drain_gnt", {31'd0, dr_gnt}, 1);
    check("drain_we", {31'd0, mem_we}, 1);
    check("drain_re", {31'd0, mem_re}, 0);
    check("drain_addr", 32'(mem_addr), 32'h0ABCD);
    check("drain_wdata", 32'(mem_wdata), 32'hC0DE);
    check("drain_busy", {31'd0, fetch_busy}, 1);
    adv();
    dr_req = 0;
    run_to_idle(50);
    check("a_lb_writes", lbw, 320);
    check("a_lb_bad", lb_bad, 0);
    check("a_first_lb", first_lb - t, 3);
    check("a_busy_fall", last_busy + 1 - t, 323);
    check("a_gnt_bad", gnt_bad, 0);

    // Fetch of line 3 with the draw engine requesting continuously.
    clr(960);
    dr_req = 1; dr_addr = 17'h1F000; dr_data = 16'h0F0F;
    line_req = 1; line_num = 9'd3;
    half(); t = cyc; adv();
    line_req = 0;
    run_to_idle(500);
    dr_req = 0;
    check("b_grants", gnt_fetch, 39);
    check("b_re_we_both", both_hi, 0);
    check("b_busy_fall", last_busy + 1 - t, 362);
    check("b_lb_writes", lbw, 320);
    check("b_lb_bad", lb_bad, 0);
    check("b_reads", reads, 320);
    check("b_gnt_bad", gnt_bad, 0);

    // Overrun: request line 5 while line 3 is at column 100.
    clr(960);
    line_req = 1; line_num = 9'd3;
    half(); adv();
    line_req = 0;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      half();
      if (mem_re && mem_addr == 17'd1059) found = 1;
      adv();
    end
    check("c_col99_found", {31'd0, found}, 1);
    line_req = 1; line_num = 9'd5;
    half();
    clr(1600);
    adv();
    line_req = 0;
    run_to_idle(400);
    check("c_overrun", {31'd0, fetch_overrun}, 1);
    check("c_lb_writes", lbw, 320);
    check("c_lb_bad", lb_bad, 0);
    check("c_reads", reads, 320);

    // Out-of-range request while busy aborts straight to IDLE.
    clr(3200);
    line_req = 1; line_num = 9'd10;
    half(); adv();
    line_req = 0;
    for (int i = 0; i < 20; i++) begin half(); adv(); end
    line_req = 1; line_num = 9'd250;
    half();
    clr(0);
    adv();
    line_req = 0;
    half();
    check("d_busy_after_abort", {31'd0, fetch_busy}, 0);
    adv();
    repeat (5) begin half(); adv(); end
    check("d_lb_writes", lbw, 0);
    check("d_reads", reads, 0);
    check("d_overrun_sticky", {31'd0, fetch_overrun}, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
